// File: rtl/spi_master_multi.sv
// spi_master_multi: multi-CS SPI master, per-frame CPOL/CPHA/bit-order/divider, word-stream bursts; ports clk/arstn, cfg_*, cs_sel, tx_* stream, rx_valid/rx_data, busy, sclk/csn/mosi/miso; `SPI_MASTER_MULTI_LOOPBACK_EN adds loopback input
module spi_master_multi #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CS     = 4,
  parameter int CS_IDX_W   = 2,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  cfg_cpol,
  input  logic                  cfg_cpha,
  input  logic                  cfg_lsb_first,
  input  logic [DIV_WIDTH-1:0]  cfg_div,
  input  logic [CS_IDX_W-1:0]   cs_sel,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_last,
  output logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  busy,
  output logic                  sclk,
  output logic [NUM_CS-1:0]     csn,
  output logic                  mosi,
`ifdef SPI_MASTER_MULTI_LOOPBACK_EN
  input  logic                  loopback,
`endif
  input  logic                  miso
);
  localparam int EW = $clog2(2 * DATA_WIDTH + 1);
  localparam logic [EW-1:0] LAST_E = EW'(2 * DATA_WIDTH);
  localparam logic [2:0] IDLE = 3'd0, SETUP = 3'd1, XFER = 3'd2, WAIT = 3'd3, HOLD = 3'd4, GAP = 3'd5;
  logic [2:0] state;
  logic [DIV_WIDTH-1:0] cnt, div_l;
  logic [EW-1:0] ecnt, e;
  logic cpol_l, cpha_l, lsb_l, last_l;
  logic [DATA_WIDTH-1:0] tx_sh, rx_sh, rx_next, src, nsh;
  logic [NUM_CS-1:0] cs_dec;
  logic hp, e_last, smp, drive, din, hd;
  assign tx_ready = state == IDLE || state == WAIT;
  assign busy = state != IDLE;
  assign hp = cnt == div_l;
  assign e = ecnt + 1'b1;
  assign e_last = e == LAST_E;
  assign smp = cpha_l ? ~e[0] : e[0];
  assign drive = cpha_l ? e[0] : ~e[0] & ~e_last;
`ifdef SPI_MASTER_MULTI_LOOPBACK_EN
  assign din = loopback ? mosi : miso;
`else
  assign din = miso;
`endif
  assign rx_next = lsb_l ? {din, rx_sh[DATA_WIDTH-1:1]} : {rx_sh[DATA_WIDTH-2:0], din};
  assign src = state == WAIT ? tx_data : tx_sh;
  assign hd = lsb_l ? src[0] : src[DATA_WIDTH-1];
  assign nsh = lsb_l ? src >> 1 : src << 1;
  always_comb begin
    cs_dec = '0;
    for (int i = 0; i < NUM_CS; i++) cs_dec[i] = int'(cs_sel) == i;
  end
  always_ff @(posedge clk) begin
    if (!arstn) begin
      state <= IDLE;
      cnt <= '0;
      ecnt <= '0;
      div_l <= '0;
      cpol_l <= 1'b0;
      cpha_l <= 1'b0;
      lsb_l <= 1'b0;
      last_l <= 1'b0;
      tx_sh <= '0;
      rx_sh <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      sclk <= 1'b0;
      csn <= '1;
      mosi <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      cnt <= (hp || state == IDLE || state == WAIT) ? '0 : cnt + 1'b1;
      case (state)
        IDLE: begin
          sclk <= cfg_cpol;
          if (tx_valid) begin
            state <= SETUP;
            div_l <= cfg_div;
            cpol_l <= cfg_cpol;
            cpha_l <= cfg_cpha;
            lsb_l <= cfg_lsb_first;
            last_l <= tx_last;
            tx_sh <= tx_data;
            csn <= ~cs_dec;
          end
        end
        SETUP: if (hp) begin
          state <= XFER;
          ecnt <= '0;
          if (!cpha_l) begin
            mosi <= hd;
            tx_sh <= nsh;
          end
        end
        XFER: if (hp) begin
          sclk <= ~sclk;
          ecnt <= e_last ? '0 : e;
          if (drive) begin
            mosi <= hd;
            tx_sh <= nsh;
          end
          if (smp) rx_sh <= rx_next;
          if (smp && e >= LAST_E - 1'b1) begin
            rx_valid <= 1'b1;
            rx_data <= rx_next;
          end
          if (e_last) state <= last_l ? HOLD : WAIT;
        end
        WAIT: begin
          sclk <= cpol_l;
          if (tx_valid) begin
            state <= XFER;
            ecnt <= '0;
            last_l <= tx_last;
            tx_sh <= cpha_l ? tx_data : nsh;
            if (!cpha_l) mosi <= hd;
          end
        end
        HOLD: if (hp) begin
          state <= GAP;
          csn <= '1;
          mosi <= 1'b0;
        end
        GAP: if (hp) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master_multi.sv
// tb_spi_master_multi: scoreboard bench for spi_master_multi with a behavioural SPI slave
module tb_spi_master_multi;
  localparam int W = 8, NCS = 4, CW = 3, DW = 8;
  logic clk = 1'b0, arstn = 1'b0;
  logic cfg_cpol = 1'b0, cfg_cpha = 1'b0, cfg_lsb_first = 1'b0;
  logic [DW-1:0] cfg_div = '0;
  logic [CW-1:0] cs_sel = '0;
  logic tx_valid = 1'b0, tx_last = 1'b0, miso = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic tx_ready, rx_valid, busy, sclk, mosi;
  logic [W-1:0] rx_data;
  logic [NCS-1:0] csn;
`ifdef SPI_MASTER_MULTI_LOOPBACK_EN
  logic loopback = 1'b0;
`endif
  always #5 clk = ~clk;
  spi_master_multi #(.DATA_WIDTH(W), .NUM_CS(NCS), .CS_IDX_W(CW), .DIV_WIDTH(DW)) dut (
    .clk(clk), .arstn(arstn), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha), .cfg_lsb_first(cfg_lsb_first),
    .cfg_div(cfg_div), .cs_sel(cs_sel), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_last(tx_last), .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy), .sclk(sclk), .csn(csn),
`ifdef SPI_MASTER_MULTI_LOOPBACK_EN
    .loopback(loopback),
`endif
    .mosi(mosi), .miso(miso));
  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask
  logic [7:0] exp_rx[$], exp_mo[$], s_q[$], fw[$], fr[$], fe[$];
  logic s_en = 1'b0, s_cpol = 1'b0, s_cpha = 1'b0, s_lsb = 1'b0;
  logic [7:0] s_word = '0, s_rx = '0;
  int s_oi = 0, s_ii = 0, s_edges = 0, n_rxv = 0;
  int cs_low[NCS], cs_rise[NCS];
  logic [NCS-1:0] csn_q = '1;
  function automatic logic sbit(input logic [7:0] w, input int i, input logic lsb);
    logic [7:0] t;
    t = lsb ? w >> i : w << i;
    return lsb ? t[0] : t[7];
  endfunction
  task automatic s_load();
    s_word = s_q.size() > 0 ? s_q.pop_front() : 8'h00;
    s_oi = 0;
    s_ii = 0;
    s_rx = '0;
    if (!s_cpha) begin
      miso = sbit(s_word, 0, s_lsb);
      s_oi = 1;
    end
  endtask
  always @(sclk) begin
    logic lead;
    if (s_en) begin
      lead = sclk != s_cpol;
      s_edges++;
      if (lead ^ s_cpha) begin
        s_rx = s_lsb ? {mosi, s_rx[7:1]} : {s_rx[6:0], mosi};
        s_ii++;
        if (s_ii == 8) begin
          if (exp_mo.size() > 0) chk("mosi_word", 32'(s_rx), 32'(exp_mo.pop_front()));
          else chk("mosi_queue", 32'(exp_mo.size()), 32'd1);
        end
      end else if (s_oi < 8) begin
        miso = sbit(s_word, s_oi, s_lsb);
        s_oi++;
      end
      if (s_edges % 16 == 0) s_load();
    end
  end
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      n_rxv++;
      if (exp_rx.size() > 0) chk("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
      else chk("rx_queue", 32'(exp_rx.size()), 32'd1);
    end
    for (int i = 0; i < NCS; i++) begin
      if (csn[i] === 1'b0) cs_low[i]++;
      if (csn[i] === 1'b1 && csn_q[i] === 1'b0) cs_rise[i]++;
    end
    csn_q = csn;
  end
  task automatic wait_ready();
    int b = 0;
    while (!tx_ready && b < 2000) begin
      @(negedge clk);
      b++;
    end
    if (b >= 2000) chk("ready_timeout", 32'(tx_ready), 32'd1);
  endtask
  task automatic send(input logic [7:0] d, input logic last);
    tx_data = d;
    tx_last = last;
    tx_valid = 1'b1;
    wait_ready();
    @(negedge clk);
    tx_valid = 1'b0;
  endtask
  task automatic wait_idle();
    int b = 0;
    while (busy && b < 5000) begin
      @(negedge clk);
      b++;
    end
    if (b >= 5000) chk("idle_timeout", 32'(busy), 32'd0);
  endtask
  task automatic prep(input logic cpol, input logic cpha, input logic lsb, input logic [7:0] div, input logic [2:0] cs);
    cfg_cpol = cpol;
    cfg_cpha = cpha;
    cfg_lsb_first = lsb;
    cfg_div = div;
    cs_sel = cs;
    repeat (2) @(negedge clk);
    chk("idle_sclk", 32'(sclk), 32'(cpol));
    s_cpol = cpol;
    s_cpha = cpha;
    s_lsb = lsb;
    s_edges = 0;
    n_rxv = 0;
    for (int i = 0; i < NCS; i++) begin
      cs_low[i] = 0;
      cs_rise[i] = 0;
    end
    foreach (fw[i]) begin
      exp_mo.push_back(fw[i]);
      s_q.push_back(fr[i]);
    end
    foreach (fe[i]) exp_rx.push_back(fe[i]);
    s_load();
    s_en = 1'b1;
  endtask
  task automatic frame(input logic cpol, input logic cpha, input logic lsb, input logic [7:0] div, input logic [2:0] cs, input int stall);
    logic [NCS-1:0] t;
    int k;
    prep(cpol, cpha, lsb, div, cs);
    for (int i = 0; i < fw.size(); i++) begin
      if (i == 1 && stall > 0) begin
        wait_ready();
        repeat (stall) @(negedge clk);
        t = csn >> cs;
        chk("wait_sclk", 32'(sclk), 32'(cpol));
        chk("wait_csn", 32'(t[0]), 32'd0);
        chk("wait_ready", 32'(tx_ready), 32'd1);
      end
      send(fw[i], i == fw.size() - 1);
      if (i == 1 && stall > 0) begin
        k = 1;
        while (sclk == cpol && k < 100) begin
          @(negedge clk);
          k++;
        end
        chk("wait_first_edge", 32'(k), 32'(div) + 32'd2);
      end
    end
    wait_idle();
    s_en = 1'b0;
    chk("sclk_edges", 32'(s_edges), 32'(16 * fw.size()));
    chk("rx_pulses", 32'(n_rxv), 32'(fe.size()));
    chk("end_sclk", 32'(sclk), 32'(cpol));
    chk("end_csn", 32'(csn), 32'hF);
  endtask
  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_csn", 32'(csn), 32'hF);
    chk("rst_mosi", 32'(mosi), 32'd0);
    arstn = 1'b1;
    fw = '{8'hA5}; fr = '{8'h3C}; fe = '{8'h3C};
    frame(1'b0, 1'b0, 1'b0, 8'd4, 3'd1, 0);
    chk("cs1_low_cycles", 32'(cs_low[1]), 32'd90);
    chk("cs1_rises", 32'(cs_rise[1]), 32'd1);
    chk("cs0_low", 32'(cs_low[0]), 32'd0);
    chk("cs2_low", 32'(cs_low[2]), 32'd0);
    chk("cs3_low", 32'(cs_low[3]), 32'd0);
    for (int m = 0; m < 4; m++) begin
      fw = '{8'h81}; fr = '{8'h7E}; fe = '{8'h7E};
      frame(logic'(m >> 1), logic'(m & 1), 1'b1, 8'd0, 3'd0, 0);
    end
    fw = '{8'h11, 8'h22, 8'h33}; fr = '{8'hEE, 8'hDD, 8'hCC}; fe = '{8'hEE, 8'hDD, 8'hCC};
    frame(1'b1, 1'b0, 1'b0, 8'd1, 3'd2, 20);
    chk("burst_cs2_rises", 32'(cs_rise[2]), 32'd1);
    fw = '{8'h5A}; fr = '{8'hB4}; fe = '{};
    prep(1'b1, 1'b0, 1'b0, 8'd2, 3'd0);
    send(8'h5A, 1'b1);
    for (int b = 0; s_edges < 7 && b < 500; b++) @(negedge clk);
    chk("abort_edge_reached", 32'(s_edges), 32'd7);
    s_en = 1'b0;
    arstn = 1'b0;
    @(negedge clk);
    chk("abort_tx_ready", 32'(tx_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rx_valid", 32'(rx_valid), 32'd0);
    chk("abort_rx_data", 32'(rx_data), 32'd0);
    chk("abort_sclk", 32'(sclk), 32'd0);
    chk("abort_csn", 32'(csn), 32'hF);
    chk("abort_mosi", 32'(mosi), 32'd0);
    arstn = 1'b1;
    exp_rx.delete(); exp_mo.delete(); s_q.delete();
    fw = '{8'h96}; fr = '{8'h69}; fe = '{8'h69};
    frame(1'b1, 1'b1, 1'b0, 8'd2, 3'd0, 0);
    fw = '{8'h4D}; fr = '{8'hB2}; fe = '{8'hB2};
    frame(1'b0, 1'b0, 1'b0, 8'd0, 3'd5, 0);
    for (int i = 0; i < NCS; i++) chk("cs5_no_select", 32'(cs_low[i]), 32'd0);
`ifdef SPI_MASTER_MULTI_LOOPBACK_EN
    loopback = 1'b1;
    fw = '{8'hC3}; fr = '{8'h00}; fe = '{8'hC3};
    frame(1'b0, 1'b0, 1'b0, 8'd1, 3'd0, 0);
    loopback = 1'b0;
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/spi_master_multi.md
# spi_master_multi

Next-generation SPI master for the serial_protocols SPI subsystem: one controller driving up to NUM_CS slaves. SPI mode (CPOL/CPHA), bit order and SCLK divider are selected per frame at run time rather than fixed by parameters. Multi-word bursts keep chip-select low across words through a valid/ready word stream. Sits between a register/DMA front end and the SPI pins.

## Interface
- DATA_WIDTH, 8, bits per word (≥2)
- NUM_CS, 4, number of chip-select lines (≥1)
- CS_IDX_W, 2, width of cs_sel (2^CS_IDX_W ≥ NUM_CS)
- DIV_WIDTH, 8, width of cfg_div
- clk  in  1  system clock; all logic on rising edge
- arstn  in  1  reset, synchronous, active-low
- cfg_cpol / cfg_cpha / cfg_lsb_first  in  1 each  SPI mode and bit order; sampled at frame start
- cfg_div  in  DIV_WIDTH  SCLK half-period = cfg_div+1 clk cycles; sampled at frame start
- cs_sel  in  CS_IDX_W  slave index; sampled at frame start
- tx_valid  in  1 / tx_ready  out  1  word handshake; transfer on clk edge with both high
- tx_data  in  DATA_WIDTH  word to send
- tx_last  in  1  qualifies tx_data; 1 = final word of frame
- rx_valid  out  1  one-cycle pulse, rx_data updated
- rx_data  out  DATA_WIDTH  received word, held until next rx_valid
- busy  out  1  high in any state other than IDLE
- sclk  out  1 / csn  out  NUM_CS  (active-low) / mosi  out  1 / miso  in  1

## Operation
- Reset values: tx_ready=1, rx_valid=0, rx_data=0, busy=0, sclk=0, csn=all 1, mosi=0, latched config=0. Reset low mid-transfer aborts on the next clk edge, with no rx_valid.
- States: IDLE, SETUP, XFER, WAIT, HOLD, GAP.
- IDLE: tx_ready=1. sclk is registered from cfg_cpol every cycle. On handshake: latch cfg_* and cs_sel, load the word, go to SETUP.
- SETUP: csn[cs_sel]=0. Lasts one half-period, then XFER. If cs_sel ≥ NUM_CS, no csn asserts but the transfer still runs.
- XFER: 2·DATA_WIDTH SCLK edges, one per half-period, numbered 1..2W. Odd edges are leading edges.
  - CPHA=0: bit0 is on mosi on entry to XFER. Sample miso on leading edges. Drive the next bit on trailing edges 2..2W-2.
  - CPHA=1: drive bit k on leading edge 2k+1. Sample on trailing edges.
  - Bit order: bit0 = MSB when lsb_first=0, LSB when 1. Received bits are assembled in the same order.
  - Counter wrap: at edge 2W, go to HOLD if the current word had tx_last=1, else go to WAIT.
- rx_valid pulses the cycle after the final sampling edge. For CPHA=0 this is edge 2W-1; for CPHA=1 it is edge 2W.
- WAIT: csn stays low, sclk=CPOL, mosi held. tx_ready=1. On handshake: load the word (config unchanged) and enter XFER directly, with no SETUP. Stalls indefinitely if tx_valid stays 0.
- HOLD: one half-period with csn low, then all csn=1 and go to GAP.
- GAP: one half-period with csn high and mosi=0, then IDLE.
- cfg_*/cs_sel changes while busy are ignored until the next frame.

## Timing
- Half-period H = cfg_div+1 cycles. cfg_div=0 gives SCLK = clk/2.
- Handshake in IDLE at cycle 0 → csn low at cycle 1 → first SCLK edge at cycle 1+H.
- One word occupies 2W·H cycles of XFER.
- WAIT handshake at cycle t → first edge of the next word at t+1+H.
- Frame end: HOLD H cycles → GAP H cycles → tx_ready=1 in IDLE.
- Minimum CS-high time between frames: H+1 cycles.
- sclk, csn and mosi are registered outputs (no combinational path from inputs).

## Configuration
- Macro SPI_MASTER_MULTI_LOOPBACK_EN.
- When defined: adds input port loopback (1 bit). When loopback=1, sampling uses the internal mosi instead of miso; sclk, csn and mosi toggle normally.
- When undefined: the port is absent and sampling always uses miso.

## Test plan
- Mode 0, MSB-first, div=4, cs_sel=1, one word 0xA5 with tx_last=1, slave returns 0x3C → mosi bits 1,0,1,0,0,1,0,1; rx_data=0x3C; csn[1] low for (1+16+1)·5 cycles; other csn stay high.
- All four CPOL/CPHA modes, LSB-first, div=0, 0x81 ↔ slave model 0x7E → correct edge alignment in each mode; sclk idles at CPOL; rx_data=0x7E.
- 3-word burst 0x11, 0x22, 0x33 (tx_last on the third), tx_valid held low 20 cycles before word 2 → csn stays low throughout; sclk stays at CPOL during WAIT; three rx_valid pulses.
- arstn low during edge 7 of a word → next cycle all outputs at reset values; no rx_valid; a new frame completes normally afterwards.
- cs_sel=5 with NUM_CS=4 → all csn stay high; 16 SCLK edges still generated; rx_valid still pulses.
- With SPI_MASTER_MULTI_LOOPBACK_EN defined, loopback=1, send 0xC3 → rx_data=0xC3 regardless of miso.
